// File: rtl/sseg_pkg.sv
// Shared seven-segment definitions for the display blocks.
//   DIGIT_SEL   : width of the digit-select field taken from the scan counter
//   NUM_DIGITS  : digits on the common-anode display
//   SSEG_*      : 7-bit active-low {g,f,e,d,c,b,a} patterns
//   digit_enable: active-low one-hot anode enable for a digit select
package sseg_pkg;

  localparam int DIGIT_SEL  = 2;
  localparam int NUM_DIGITS = 4;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [6:0] sseg_pat_t;

  localparam sseg_pat_t SSEG_BLANK = 7'b1111111;
  localparam sseg_pat_t SSEG_0     = 7'b1000000;
  localparam sseg_pat_t SSEG_1     = 7'b1111001;
  localparam sseg_pat_t SSEG_2     = 7'b0100100;
  localparam sseg_pat_t SSEG_3     = 7'b0110000;
  localparam sseg_pat_t SSEG_4     = 7'b0011001;
  localparam sseg_pat_t SSEG_5     = 7'b0010010;
  localparam sseg_pat_t SSEG_6     = 7'b0000010;
  localparam sseg_pat_t SSEG_7     = 7'b1111000;
  localparam sseg_pat_t SSEG_8     = 7'b0000000;
  localparam sseg_pat_t SSEG_9     = 7'b0010000;

  // sel=0 -> 1110, sel=1 -> 1101, ...
  function automatic logic [NUM_DIGITS-1:0] digit_enable(input logic [DIGIT_SEL-1:0] sel);
    digit_enable = ~(NUM_DIGITS'(1) << sel);
  endfunction

endpackage

// File: rtl/bcd_to_sseg.sv
// Combinational BCD digit to seven-segment decoder.
//   digit   : 4-bit BCD value
//   pattern : 7-bit active-low {g,f,e,d,c,b,a}; non-BCD codes blank
module bcd_to_sseg
  import sseg_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SSEG_BLANK;
    case (digit)
      4'd0: pattern = SSEG_0;
      4'd1: pattern = SSEG_1;
      4'd2: pattern = SSEG_2;
      4'd3: pattern = SSEG_3;
      4'd4: pattern = SSEG_4;
      4'd5: pattern = SSEG_5;
      4'd6: pattern = SSEG_6;
      4'd7: pattern = SSEG_7;
      4'd8: pattern = SSEG_8;
      4'd9: pattern = SSEG_9;
      default: pattern = SSEG_BLANK;
    endcase
  end

endmodule

// File: rtl/tick_bcd_display.sv
// Counts rising edges of an upstream tick in 4-digit native BCD and drives a
// multiplexed, active-low, common-anode seven-segment display.
//   clk, reset    : clock, async active-high reset
//   in_tick       : event input; only 0->1 transitions count
//   clear         : sync clear of the count (beats hold)
//   hold          : freeze count; events during hold are dropped
//   bcd           : {d3,d2,d1,d0}, d0 = units
//   overflow_tick : one-cycle pulse on 9999->0000
//   an            : active-low digit enables
//   seg           : {dp,g,f,e,d,c,b,a}, active-low, dp always off
module tick_bcd_display
  import sseg_pkg::*;
#(
  parameter int REFRESH_BITS = 18
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_tick,
  input  logic        clear,
  input  logic        hold,
  output logic [15:0] bcd,
  output logic        overflow_tick,
  output logic [3:0]  an,
  output logic [7:0]  seg
);

  localparam int DIGITS = NUM_DIGITS;

  logic                           in_tick_d;
  logic                           tick_evt;
  logic [DIGITS-1:0][3:0]         bcd_q;
  logic [DIGITS-1:0][3:0]         bcd_nxt;
  logic [DIGITS:0]                carry;
  logic [REFRESH_BITS-1:0]        refresh_cnt;
  logic [DIGIT_SEL-1:0]           sel;
  logic [DIGITS-1:0][6:0]         pat;

  assign tick_evt = in_tick & ~in_tick_d;

  // Ripple-carry BCD increment; carry out of the top digit is the wrap.
  always_comb begin
    bcd_nxt  = bcd_q;
    carry    = '0;
    carry[0] = tick_evt;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry[i]) begin
        if (bcd_q[i] == 4'd9) begin
          bcd_nxt[i]   = 4'd0;
          carry[i+1]   = 1'b1;
        end else begin
          bcd_nxt[i]   = bcd_q[i] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_tick_d     <= 1'b0;
      bcd_q         <= '0;
      overflow_tick <= 1'b0;
    end else begin
      // Edge history tracks the input regardless of clear/hold.
      in_tick_d <= in_tick;
      if (clear) begin
        bcd_q         <= '0;
        overflow_tick <= 1'b0;
      end else if (hold) begin
        // Count frozen; the wrap flag is a pulse, so it still drops.
        overflow_tick <= 1'b0;
      end else begin
        bcd_q         <= bcd_nxt;
        overflow_tick <= carry[DIGITS];
      end
    end
  end

  assign bcd = bcd_q;

  // Free-running scan counter; unaffected by clear/hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) refresh_cnt <= '0;
    else       refresh_cnt <= refresh_cnt + REFRESH_BITS'(1);
  end

  assign sel = refresh_cnt[REFRESH_BITS-1 -: DIGIT_SEL];

  // One decoder per digit, then mux the selected pattern out.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    bcd_to_sseg u_dec (
      .digit   (bcd_q[g]),
      .pattern (pat[g])
    );
  end

  assign an  = digit_enable(sel);
  assign seg = {1'b1, pat[sel]};

endmodule
